// File: rtl/fetch_predict_unit.sv
// ---------------------------------------------------------------------------
// fetch_predict_unit
//   Fetch segment for the pipelined core. It owns the PC register and holds a
//   direct-mapped branch target buffer (BTB) with 2-bit saturating counters,
//   so predicted-taken branches redirect at fetch. Branch resolution from
//   execute trains the BTB and drives mispredict recovery. Two saturating
//   performance counters track resolved branches and mispredicts.
//
// Ports
//   clk, reset            clock / asynchronous active-low reset
//   stallF                hold PC
//   pcSrcW, resultW       write-back PC write (highest priority)
//   resolveE, takenE,     branch resolution from execute
//   pcE, targetE,
//   predTakenE,           prediction carried down from fetch
//   predTargetE
//   pc                    current fetch PC
//   predTakenF,           BTB lookup result for pc
//   predTargetF
//   mispredictE           execute redirect (combinational)
//   branchCount,          saturating performance counters
//   mispredCount
// ---------------------------------------------------------------------------
module fetch_predict_unit #(
    parameter int               WIDTH    = 32,
    parameter int               PCADD    = 4,
    parameter int               ENTRIES  = 16,
    parameter int               IDXW     = $clog2(ENTRIES),
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               CNTW     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallF,
    input  logic             pcSrcW,
    input  logic [WIDTH-1:0] resultW,
    input  logic             resolveE,
    input  logic             takenE,
    input  logic [WIDTH-1:0] pcE,
    input  logic [WIDTH-1:0] targetE,
    input  logic             predTakenE,
    input  logic [WIDTH-1:0] predTargetE,
    output logic [WIDTH-1:0] pc,
    output logic             predTakenF,
    output logic [WIDTH-1:0] predTargetF,
    output logic             mispredictE,
    output logic [CNTW-1:0]  branchCount,
    output logic [CNTW-1:0]  mispredCount
);
    localparam int TAGW = WIDTH - IDXW - 2;

    logic [WIDTH-1:0]                pc_q, pc_d;
    logic [ENTRIES-1:0]              valid_q;
    logic [ENTRIES-1:0][TAGW-1:0]    tag_q;
    logic [ENTRIES-1:0][WIDTH-1:0]   tgt_q;
    logic [ENTRIES-1:0][1:0]         ctr_q;
    logic [CNTW-1:0]                 brcnt_q, mpcnt_q;

    // Fetch-side lookup reads the registered table, so a same-cycle training
    // write to the same index is only seen on the following cycle.
    logic [IDXW-1:0] idx_f;
    logic [TAGW-1:0] tag_f;
    logic            hit_f;

    assign idx_f       = pc_q[IDXW+1:2];
    assign tag_f       = pc_q[WIDTH-1:IDXW+2];
    assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign predTakenF  = hit_f && ctr_q[idx_f][1];
    assign predTargetF = hit_f ? tgt_q[idx_f] : '0;

    // Execute-side lookup used for training.
    logic [IDXW-1:0]  idx_e;
    logic [TAGW-1:0]  tag_e;
    logic             hit_e;
    logic [WIDTH-1:0] recover_pc;

    assign idx_e = pcE[IDXW+1:2];
    assign tag_e = pcE[WIDTH-1:IDXW+2];
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    // A correct direction with a stale target still counts as a mispredict.
    assign mispredictE = resolveE &&
                         ((takenE != predTakenE) ||
                          (takenE && predTakenE && (targetE != predTargetE)));
    assign recover_pc  = takenE ? targetE : pcE + WIDTH'(PCADD);

    always_comb begin
        pc_d = pc_q + WIDTH'(PCADD);
        if (pcSrcW)           pc_d = resultW;
        else if (mispredictE) pc_d = recover_pc;
        else if (stallF)      pc_d = pc_q;
        else if (predTakenF)  pc_d = predTargetF;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    // BTB training: strengthen/weaken on hit, allocate on taken miss.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
            ctr_q   <= {ENTRIES{2'b01}};
        end else if (resolveE) begin
            if (hit_e) begin
                if (takenE) begin
                    if (ctr_q[idx_e] != 2'b11) ctr_q[idx_e] <= ctr_q[idx_e] + 2'd1;
                    tgt_q[idx_e] <= targetE;
                end else if (ctr_q[idx_e] != 2'b00) begin
                    ctr_q[idx_e] <= ctr_q[idx_e] - 2'd1;
                end
            end else if (takenE) begin
                valid_q[idx_e] <= 1'b1;
                tag_q[idx_e]   <= tag_e;
                tgt_q[idx_e]   <= targetE;
                ctr_q[idx_e]   <= 2'b10;
            end
        end
    end

    // Performance counters stick at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brcnt_q <= '0;
            mpcnt_q <= '0;
        end else begin
            if (resolveE && (brcnt_q != '1))    brcnt_q <= brcnt_q + 1'b1;
            if (mispredictE && (mpcnt_q != '1)) mpcnt_q <= mpcnt_q + 1'b1;
        end
    end

    assign pc           = pc_q;
    assign branchCount  = brcnt_q;
    assign mispredCount = mpcnt_q;

endmodule

// File: tb/tb_fetch_predict_unit.sv
module tb_fetch_predict_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        stallF, pcSrcW, resolveE, takenE, predTakenE;
    logic [31:0] resultW, pcE, targetE, predTargetE;
    logic [31:0] pc, predTargetF;
    logic        predTakenF, mispredictE;
    logic [3:0]  branchCount, mispredCount;

    fetch_predict_unit #(.WIDTH(32), .PCADD(4), .ENTRIES(16), .RESET_PC(32'h0), .CNTW(4)) dut (
        .clk(clk), .reset(reset), .stallF(stallF), .pcSrcW(pcSrcW), .resultW(resultW),
        .resolveE(resolveE), .takenE(takenE), .pcE(pcE), .targetE(targetE),
        .predTakenE(predTakenE), .predTargetE(predTargetE), .pc(pc),
        .predTakenF(predTakenF), .predTargetF(predTargetF), .mispredictE(mispredictE),
        .branchCount(branchCount), .mispredCount(mispredCount)
    );

    always #5 clk = ~clk;

    typedef struct { string name; logic [31:0] val; } exp_t;
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic push(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic pop(input logic [31:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL sb_empty got=%0h want=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s got=%0h want=%0h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stallF = 0; pcSrcW = 0; resultW = 0; resolveE = 0; takenE = 0;
        pcE = 0; targetE = 0; predTakenE = 0; predTargetE = 0;
    endtask

    task automatic resolve(input logic [31:0] p, input logic tk, input logic [31:0] t,
                           input logic ptk, input logic [31:0] pt);
        resolveE = 1; pcE = p; takenE = tk; targetE = t; predTakenE = ptk; predTargetE = pt;
    endtask

    task automatic redirect(input logic [31:0] a);
        pcSrcW = 1; resultW = a;
        tick();
        idle();
        #1;
    endtask

    initial begin
        idle();
        reset = 0;
        #12 reset = 1;
        #1;
        // 1. reset state and sequential fetch
        push("rst_pc", 0);          pop(pc);
        push("rst_pt", 0);          pop(32'(predTakenF));
        push("rst_bc", 0);          pop(32'(branchCount));
        push("rst_mc", 0);          pop(32'(mispredCount));
        push("seq_pc4", 32'h4);     tick(); pop(pc);
        push("seq_pc8", 32'h8);     tick(); pop(pc);
        push("seq_pc12", 32'hc);    tick(); pop(pc);

        // 2. taken branch mispredicted, then predicted at fetch
        resolve(32'h20, 1, 32'h100, 0, 0); #1;
        push("t2_mis", 1);          pop(32'(mispredictE));
        push("t2_pc", 32'h100);     tick(); pop(pc);
        idle();
        push("t2_mc", 1);           pop(32'(mispredCount));
        push("t2_bc", 1);           pop(32'(branchCount));
        redirect(32'h20);
        push("t2_ptk", 1);          pop(32'(predTakenF));
        push("t2_ptg", 32'h100);    pop(predTargetF);
        push("t2_predpc", 32'h100); tick(); pop(pc);

        // 3. three not-taken resolves: ctr 2->1->0->0
        resolve(32'h20, 0, 32'h100, 1, 32'h100); #1;
        push("t3_mis1", 1);         pop(32'(mispredictE));
        push("t3_rec", 32'h24);     tick(); pop(pc);
        resolve(32'h20, 0, 32'h100, 0, 0); pcSrcW = 1; resultW = 32'h20; #1;
        push("t3_mis2", 0);         pop(32'(mispredictE));
        tick();
        resolve(32'h20, 0, 32'h100, 0, 0); pcSrcW = 0; stallF = 1; #1;
        push("t3_ptk", 0);          pop(32'(predTakenF));
        push("t3_ptg", 32'h100);    pop(predTargetF);
        push("t3_mis3", 0);         pop(32'(mispredictE));
        push("t3_stall", 32'h20);   tick(); pop(pc);
        idle(); #1;
        push("t3_ptk3", 0);         pop(32'(predTakenF));
        push("t3_seq", 32'h24);     tick(); pop(pc);
        push("t3_bc", 4);           pop(32'(branchCount));
        push("t3_mc", 2);           pop(32'(mispredCount));

        // 4. pcSrcW beats mispredict and stall; training still happens
        stallF = 1; pcSrcW = 1; resultW = 32'h400;
        resolve(32'h20, 1, 32'h200, 0, 0); #1;
        push("t4_mis", 1);          pop(32'(mispredictE));
        push("t4_pc", 32'h400);     tick(); pop(pc);
        idle();
        push("t4_bc", 5);           pop(32'(branchCount));
        push("t4_mc", 3);           pop(32'(mispredCount));
        redirect(32'h20);
        push("t4_ptk", 0);          pop(32'(predTakenF));
        push("t4_ptg", 32'h200);    pop(predTargetF);
        // same-index write during lookup: lookup sees old contents
        resolve(32'h20, 1, 32'h300, 0, 0); #1;
        push("col_ptk", 0);         pop(32'(predTakenF));
        push("col_ptg", 32'h200);   pop(predTargetF);
        push("col_pc", 32'h300);    tick(); pop(pc);
        idle();
        redirect(32'h20);
        push("col_ptk2", 1);        pop(32'(predTakenF));
        push("col_ptg2", 32'h300);  pop(predTargetF);
        push("col_pred", 32'h300);  tick(); pop(pc);

        // 5. alias at same index, different tag
        redirect(32'h420);
        push("al_ptk", 0);          pop(32'(predTakenF));
        push("al_ptg", 0);          pop(predTargetF);
        resolve(32'h420, 1, 32'h500, 0, 0);
        push("al_pc", 32'h500);     tick(); pop(pc);
        idle();
        redirect(32'h20);
        push("al_old", 0);          pop(32'(predTakenF));
        resolve(32'h60, 0, 0, 0, 0); #1;   // not-taken miss leaves the entry alone
        push("al_nt_mis", 0);       pop(32'(mispredictE));
        tick(); idle();
        redirect(32'h420);
        push("al_new_ptk", 1);      pop(32'(predTakenF));
        push("al_new_ptg", 32'h500); pop(predTargetF);

        // recovery wrap and target-mismatch mispredict
        resolve(32'hFFFF_FFFC, 0, 0, 1, 32'h1234);
        push("wrap_pc", 0);         tick(); pop(pc);
        resolve(32'h420, 1, 32'h600, 1, 32'h500); #1;
        push("tgt_mis", 1);         pop(32'(mispredictE));
        push("tgt_pc", 32'h600);    tick(); pop(pc);
        resolve(32'h420, 1, 32'h600, 1, 32'h600); #1;
        push("ok_mis", 0);          pop(32'(mispredictE));
        tick(); idle();
        push("pre_bc", 11);         pop(32'(branchCount));
        push("pre_mc", 7);          pop(32'(mispredCount));

        // 6. counter saturation at CNTW=4
        for (int i = 0; i < 20; i++) begin
            resolve(32'h80, 0, 0, 0, 0);
            tick();
        end
        idle();
        push("sat_bc", 15);         pop(32'(branchCount));
        push("sat_mc", 7);          pop(32'(mispredCount));
        for (int i = 0; i < 20; i++) begin
            resolve(32'h80, 0, 0, 1, 32'h90);
            tick();
        end
        push("sat_mc2", 15);        pop(32'(mispredCount));
        push("sat_pc", 32'h84);     pop(pc);

        // asynchronous reset mid-run, away from the clock edge
        #2 reset = 0;
        #1;
        push("ar_pc", 0);           pop(pc);
        push("ar_bc", 0);           pop(32'(branchCount));
        push("ar_mc", 0);           pop(32'(mispredCount));
        push("ar_mis_held", 1);     pop(32'(mispredictE));
        idle();
        #2 reset = 1;
        #1;
        push("ar_first", 0);        pop(pc);
        push("ar_next", 32'h4);     tick(); pop(pc);
        redirect(32'h420);
        push("ar_btb_ptk", 0);      pop(32'(predTakenF));
        push("ar_btb_ptg", 0);      pop(predTargetF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog: the directed sequence is short; never let the run hang.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule
